// File: rtl/wb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wb_pkg : shared types for the writeback arbiter         rev 1.0       |
// +-----------------------------------------------------------------------+
package wb_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    word_t    wdat;
  } wb_req_t;

  localparam int WB_DEPTH = 2;

  function automatic word_t reg_onehot(input regbits_t r);
    reg_onehot = word_t'(1) << r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wb_queue : MDU result FIFO with match-invalidate and busy mask rev 1.0|
// +-----------------------------------------------------------------------+
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic     clk,
  input  logic     rst_i,
  input  logic     push_i,
  input  wb_req_t  push_req_i,
  input  logic     pop_i,
  input  logic     kill_en_i,
  input  regbits_t kill_sel_i,
  output wb_req_t  head_o,
  output logic     full_o,
  output logic     empty_o,
  output word_t    busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          ent_q [DEPTH];
  wb_req_t          ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_push;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = ent_q[head_q];

  // Zero selects are dropped; a push already shadowed by the same-cycle kill is dropped too.
  assign w_push = push_i && !full_o && (push_req_i.wsel != '0) &&
                  !(kill_en_i && (push_req_i.wsel == kill_sel_i));

  always_comb begin
    logic [PTR_W-1:0] last;
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    last   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en_i && ent_d[i].valid && (ent_d[i].wsel == kill_sel_i)) begin
        ent_d[i].valid = 1'b0;
      end
    end
    if (pop_i && !empty_o) begin
      ent_d[head_q].valid = 1'b0;
    end
    if (w_push) begin
      ent_d[tail_q] = '{valid: 1'b1, wsel: push_req_i.wsel, wdat: push_req_i.wdat};
      tail_d        = tail_q + 1'b1;
      cnt_d         = cnt_q + 1'b1;
    end
    // Trim dead slots from both ends so the head is always a live entry.
    for (int i = 0; i < DEPTH; i++) begin
      if ((cnt_d != '0) && !ent_d[head_d].valid) begin
        head_d = head_d + 1'b1;
        cnt_d  = cnt_d - 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      last = tail_d - 1'b1;
      if ((cnt_d != '0) && !ent_d[last].valid) begin
        tail_d = last;
        cnt_d  = cnt_d - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        busy_o = busy_o | reg_onehot(ent_q[i].wsel);
      end
    end
    busy_o[0] = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wb_arbiter : pipeline/MDU writeback merge into one RF port  rev 1.0   |
// +-----------------------------------------------------------------------+
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_wsel,
  input  logic [31:0] pipe_wdat,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_wsel,
  input  logic [31:0] mdu_wdat,
  output logic        rf_WEN,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic [31:0] pend_busy
);

  logic     w_pipe_win;
  logic     w_pop;
  logic     w_full;
  logic     w_empty;
  wb_req_t  w_head;
  wb_req_t  w_mdu_req;
  logic     rf_wen_q, rf_wen_d;
  regbits_t rf_wsel_q, rf_wsel_d;
  word_t    rf_wdat_q, rf_wdat_d;

  // A write to r0 is a no-op, so it neither wins the port nor kills queued entries.
  assign w_pipe_win = pipe_valid && (pipe_wsel != '0);
  assign mdu_ready  = !w_full && !n_rst;
  assign w_mdu_req  = '{valid: 1'b1, wsel: mdu_wsel, wdat: mdu_wdat};

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_i      (n_rst),
    .push_i     (mdu_valid && mdu_ready),
    .push_req_i (w_mdu_req),
    .pop_i      (w_pop),
    .kill_en_i  (w_pipe_win),
    .kill_sel_i (pipe_wsel),
    .head_o     (w_head),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .busy_o     (pend_busy)
  );

  always_comb begin
    rf_wen_d  = 1'b0;
    rf_wsel_d = rf_wsel_q;
    rf_wdat_d = rf_wdat_q;
    w_pop     = 1'b0;
    if (w_pipe_win) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = pipe_wsel;
      rf_wdat_d = pipe_wdat;
    end else if (!w_empty && w_head.valid) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = w_head.wsel;
      rf_wdat_d = w_head.wdat;
      w_pop     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      rf_wen_q  <= 1'b0;
      rf_wsel_q <= '0;
      rf_wdat_q <= '0;
    end else begin
      rf_wen_q  <= rf_wen_d;
      rf_wsel_q <= rf_wsel_d;
      rf_wdat_q <= rf_wdat_d;
    end
  end

  assign rf_WEN  = rf_wen_q;
  assign rf_wsel = rf_wsel_q;
  assign rf_wdat = rf_wdat_q;

endmodule
`default_nettype wire
